// File: rtl/bp_me_dma_bank_mux.sv
// Merges per-bank DMA channels onto one DRAM port: round-robin packet arbitration,
// write-burst forwarding from the granted bank, and in-order read return via a bank tag FIFO.
module bp_me_dma_bank_mux #(
    parameter int banks_p               = 2,
    parameter int daddr_width_p         = 32,
    parameter int block_size_in_words_p = 8,
    parameter int fill_width_p          = 64,
    parameter int block_beats_p         = 8,
    parameter int max_outstanding_p     = 4
) (
    input  logic                                                           clk_i,
    input  logic                                                           reset_i,
    input  logic [banks_p-1:0][1+daddr_width_p+block_size_in_words_p-1:0] bank_pkt_i,
    input  logic [banks_p-1:0]                                             bank_pkt_v_i,
    output logic [banks_p-1:0]                                             bank_pkt_ready_and_o,
    input  logic [banks_p-1:0][fill_width_p-1:0]                           bank_data_i,
    input  logic [banks_p-1:0]                                             bank_data_v_i,
    output logic [banks_p-1:0]                                             bank_data_ready_and_o,
    output logic [banks_p-1:0][fill_width_p-1:0]                           bank_data_o,
    output logic [banks_p-1:0]                                             bank_data_v_o,
    input  logic [banks_p-1:0]                                             bank_data_ready_and_i,
    output logic [1+daddr_width_p+block_size_in_words_p-1:0]               dma_pkt_o,
    output logic                                                           dma_pkt_v_o,
    input  logic                                                           dma_pkt_ready_and_i,
    output logic [fill_width_p-1:0]                                        dma_data_o,
    output logic                                                           dma_data_v_o,
    input  logic                                                           dma_data_ready_and_i,
    input  logic [fill_width_p-1:0]                                        dma_data_i,
    input  logic                                                           dma_data_v_i,
    output logic                                                           dma_data_ready_and_o
);

    localparam int pkt_w  = 1 + daddr_width_p + block_size_in_words_p;
    localparam int tag_w  = (banks_p > 1) ? $clog2(banks_p) : 1;
    localparam int beat_w = (block_beats_p > 1) ? $clog2(block_beats_p) : 1;
    localparam int fptr_w = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int fcnt_w = $clog2(max_outstanding_p + 1);
    localparam logic [beat_w-1:0] LAST_BEAT = beat_w'(block_beats_p - 1);

    typedef enum logic {ST_IDLE, ST_WRITE} state_t;

    state_t             r_state;
    logic [tag_w-1:0]   r_ptr;
    logic [tag_w-1:0]   r_wbank;
    logic [tag_w-1:0]   r_lock_g;
    logic               r_locked;
    logic [beat_w-1:0]  r_wcnt;
    logic [beat_w-1:0]  r_rcnt;
    logic [tag_w-1:0]   r_tags [max_outstanding_p];
    logic [fptr_w-1:0]  r_rd;
    logic [fptr_w-1:0]  r_wr;
    logic [fcnt_w-1:0]  r_cnt;

    logic [banks_p-1:0] w_elig;
    logic [tag_w-1:0]   w_rr;
    logic [tag_w-1:0]   w_grant;
    logic [tag_w-1:0]   w_head;
    logic [31:0]        w_idx;
    logic               w_found;
    logic               w_full;
    logic               w_empty;
    logic               w_in_idle;
    logic               w_in_write;
    logic               w_pkt_xfer;
    logic               w_is_write;
    logic               w_wxfer;
    logic               w_rxfer;
    logic               w_push;
    logic               w_pop;

    assign w_full     = (r_cnt == fcnt_w'(max_outstanding_p));
    assign w_empty    = (r_cnt == '0);
    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_in_write = (r_state == ST_WRITE);
    assign w_head     = r_tags[r_rd];

    always_comb begin
        w_elig = '0;
        for (int unsigned b = 0; b < banks_p; b++) begin
            w_elig[b] = bank_pkt_v_i[b] & (bank_pkt_i[b][pkt_w-1] | ~w_full);
        end
    end

    always_comb begin
        w_rr    = r_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < banks_p; i++) begin
            w_idx = (32'(r_ptr) + i) % unsigned'(banks_p);
            if (!w_found && w_elig[tag_w'(w_idx)]) begin
                w_rr    = tag_w'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    // A presented but unaccepted packet pins the grant so the output stays stable.
    assign w_grant    = (r_locked && w_elig[r_lock_g]) ? r_lock_g : w_rr;
    assign dma_pkt_o  = bank_pkt_i[w_grant];
    assign dma_pkt_v_o = w_in_idle & (|w_elig);
    assign w_pkt_xfer = dma_pkt_v_o & dma_pkt_ready_and_i;
    assign w_is_write = dma_pkt_o[pkt_w-1];
    assign w_push     = w_pkt_xfer & ~w_is_write;

    assign dma_data_o   = bank_data_i[r_wbank];
    assign dma_data_v_o = w_in_write & bank_data_v_i[r_wbank];
    assign w_wxfer      = dma_data_v_o & dma_data_ready_and_i;

    assign bank_data_o          = {banks_p{dma_data_i}};
    assign dma_data_ready_and_o = ~w_empty & bank_data_ready_and_i[w_head];
    assign w_rxfer              = ~w_empty & dma_data_v_i & bank_data_ready_and_i[w_head];
    assign w_pop                = w_rxfer & (r_rcnt == LAST_BEAT);

    always_comb begin
        bank_pkt_ready_and_o  = '0;
        bank_data_ready_and_o = '0;
        bank_data_v_o         = '0;
        if (dma_pkt_v_o) begin
            bank_pkt_ready_and_o[w_grant] = dma_pkt_ready_and_i;
        end
        if (w_in_write) begin
            bank_data_ready_and_o[r_wbank] = dma_data_ready_and_i;
        end
        if (!w_empty) begin
            bank_data_v_o[w_head] = dma_data_v_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_tags[r_wr] <= w_grant;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_wbank  <= '0;
            r_lock_g <= '0;
            r_locked <= 1'b0;
            r_wcnt   <= '0;
            r_rcnt   <= '0;
            r_rd     <= '0;
            r_wr     <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_locked <= dma_pkt_v_o & ~dma_pkt_ready_and_i;
                    r_lock_g <= w_grant;
                    if (w_pkt_xfer) begin
                        r_ptr <= (w_grant == tag_w'(banks_p - 1)) ? '0 : w_grant + 1'b1;
                        if (w_is_write) begin
                            r_state <= ST_WRITE;
                            r_wbank <= w_grant;
                            r_wcnt  <= '0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_wxfer) begin
                        if (r_wcnt == LAST_BEAT) begin
                            r_state <= ST_IDLE;
                            r_wcnt  <= '0;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_rxfer) begin
                r_rcnt <= (r_rcnt == LAST_BEAT) ? '0 : r_rcnt + 1'b1;
            end
            if (w_push) begin
                r_wr <= (r_wr == fptr_w'(max_outstanding_p - 1)) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == fptr_w'(max_outstanding_p - 1)) ? '0 : r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_me_dma_bank_mux.sv
// Scenario bench for bp_me_dma_bank_mux: two banks, two-beat blocks, two outstanding reads.
module tb_bp_me_dma_bank_mux;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0][40:0]  bank_pkt_i = '0;
    logic [1:0]        bank_pkt_v_i = '0;
    logic [1:0]        bank_pkt_ready_and_o;
    logic [1:0][63:0]  bank_data_i = '0;
    logic [1:0]        bank_data_v_i = '0;
    logic [1:0]        bank_data_ready_and_o;
    logic [1:0][63:0]  bank_data_o;
    logic [1:0]        bank_data_v_o;
    logic [1:0]        bank_data_ready_and_i = '0;
    logic [40:0]       dma_pkt_o;
    logic              dma_pkt_v_o;
    logic              dma_pkt_ready_and_i = 1'b0;
    logic [63:0]       dma_data_o;
    logic              dma_data_v_o;
    logic              dma_data_ready_and_i = 1'b0;
    logic [63:0]       dma_data_i = '0;
    logic              dma_data_v_i = 1'b0;
    logic              dma_data_ready_and_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [40:0] exp_pkt[$];
    logic [63:0] exp_wdata[$];
    logic [64:0] exp_ret[$];

    bp_me_dma_bank_mux #(
        .banks_p(2),
        .daddr_width_p(32),
        .block_size_in_words_p(8),
        .fill_width_p(64),
        .block_beats_p(2),
        .max_outstanding_p(2)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_n),
        .bank_pkt_i(bank_pkt_i),
        .bank_pkt_v_i(bank_pkt_v_i),
        .bank_pkt_ready_and_o(bank_pkt_ready_and_o),
        .bank_data_i(bank_data_i),
        .bank_data_v_i(bank_data_v_i),
        .bank_data_ready_and_o(bank_data_ready_and_o),
        .bank_data_o(bank_data_o),
        .bank_data_v_o(bank_data_v_o),
        .bank_data_ready_and_i(bank_data_ready_and_i),
        .dma_pkt_o(dma_pkt_o),
        .dma_pkt_v_o(dma_pkt_v_o),
        .dma_pkt_ready_and_i(dma_pkt_ready_and_i),
        .dma_data_o(dma_data_o),
        .dma_data_v_o(dma_data_v_o),
        .dma_data_ready_and_i(dma_data_ready_and_i),
        .dma_data_i(dma_data_i),
        .dma_data_v_i(dma_data_v_i),
        .dma_data_ready_and_o(dma_data_ready_and_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [40:0] mkpkt(input logic w, input logic [31:0] a, input logic [7:0] m);
        return {w, a, m};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted transfer on any output channel must match the queue head.
    always @(negedge clk) begin
        logic [40:0] ep;
        logic [63:0] ew;
        logic [64:0] er;
        if (reset_n) begin
            if (dma_pkt_v_o && dma_pkt_ready_and_i) begin
                n_tests++;
                if (exp_pkt.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_pkt unexpected got=%h", dma_pkt_o);
                end else begin
                    ep = exp_pkt.pop_front();
                    if (dma_pkt_o !== ep) begin
                        n_fail++;
                        $display("FAIL sb_pkt got=%h exp=%h", dma_pkt_o, ep);
                    end
                end
            end
            if (dma_data_v_o && dma_data_ready_and_i) begin
                n_tests++;
                if (exp_wdata.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_wdata unexpected got=%h", dma_data_o);
                end else begin
                    ew = exp_wdata.pop_front();
                    if (dma_data_o !== ew) begin
                        n_fail++;
                        $display("FAIL sb_wdata got=%h exp=%h", dma_data_o, ew);
                    end
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (bank_data_v_o[b] && bank_data_ready_and_i[b]) begin
                    n_tests++;
                    if (exp_ret.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_ret unexpected bank=%0d got=%h", b, bank_data_o[b]);
                    end else begin
                        er = exp_ret.pop_front();
                        if ({1'(b), bank_data_o[b]} !== er) begin
                            n_fail++;
                            $display("FAIL sb_ret got bank=%0d data=%h exp bank=%0d data=%h",
                                     b, bank_data_o[b], er[64], er[63:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        dma_pkt_ready_and_i = 1'b1;
        dma_data_ready_and_i = 1'b1;
        bank_data_ready_and_i = 2'b11;
        dma_data_v_i = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        n_tests++;
        if (dma_pkt_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_v got=%b exp=0", dma_pkt_v_o); end
        n_tests++;
        if (dma_data_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_wdata_v got=%b exp=0", dma_data_v_o); end
        n_tests++;
        if (dma_data_ready_and_o !== 1'b0) begin n_fail++; $display("FAIL reset_ret_ready got=%b exp=0", dma_data_ready_and_o); end
        n_tests++;
        if (bank_data_v_o !== 2'b00) begin n_fail++; $display("FAIL reset_bank_v got=%b exp=00", bank_data_v_o); end
        n_tests++;
        if (bank_pkt_ready_and_o !== 2'b00) begin n_fail++; $display("FAIL reset_pkt_ready got=%b exp=00", bank_pkt_ready_and_o); end
        n_tests++;
        if (bank_data_ready_and_o !== 2'b00) begin n_fail++; $display("FAIL reset_wdata_ready got=%b exp=00", bank_data_ready_and_o); end
        cyc();
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bank_data_v_o !== 2'b00) begin n_fail++; $display("FAIL empty_fifo_bank_v got=%b exp=00", bank_data_v_o); end
        cyc();
        dma_data_v_i = 1'b0;
    endtask

    task automatic test_rr_reads();
        logic [63:0] d;
        bank_pkt_i[0] = mkpkt(1'b0, 32'h0000_1000, 8'hFF);
        bank_pkt_i[1] = mkpkt(1'b0, 32'h0000_2000, 8'h0F);
        bank_pkt_v_i = 2'b11;
        exp_pkt.push_back(bank_pkt_i[0]);
        exp_pkt.push_back(bank_pkt_i[1]);
        @(negedge clk);
        n_tests++;
        if (bank_pkt_ready_and_o !== 2'b01) begin n_fail++; $display("FAIL rr_first got=%b exp=01", bank_pkt_ready_and_o); end
        cyc();
        bank_pkt_v_i = 2'b10;
        @(negedge clk);
        n_tests++;
        if (bank_pkt_ready_and_o !== 2'b10) begin n_fail++; $display("FAIL rr_second got=%b exp=10", bank_pkt_ready_and_o); end
        cyc();
        bank_pkt_v_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            d = 64'hA0 + 64'(i);
            dma_data_i = d;
            dma_data_v_i = 1'b1;
            exp_ret.push_back({(i >= 2) ? 1'b1 : 1'b0, d});
            @(negedge clk);
            n_tests++;
            if (bank_data_v_o !== ((i < 2) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL rr_return_route beat=%0d got=%b", i, bank_data_v_o);
            end
            cyc();
        end
        dma_data_v_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (dma_data_ready_and_o !== 1'b0) begin n_fail++; $display("FAIL rr_drained_ready got=%b exp=0", dma_data_ready_and_o); end
        cyc();
    endtask

    task automatic test_outstanding();
        logic [40:0] pc;
        pc = mkpkt(1'b0, 32'h0000_3300, 8'h11);
        bank_pkt_i[0] = mkpkt(1'b0, 32'h0000_3000, 8'h01);
        bank_pkt_i[1] = mkpkt(1'b0, 32'h0000_3100, 8'h02);
        bank_pkt_v_i = 2'b11;
        exp_pkt.push_back(bank_pkt_i[0]);
        exp_pkt.push_back(bank_pkt_i[1]);
        exp_pkt.push_back(pc);
        @(negedge clk);
        n_tests++;
        if (bank_pkt_ready_and_o !== 2'b01) begin n_fail++; $display("FAIL out_first got=%b exp=01", bank_pkt_ready_and_o); end
        cyc();
        bank_pkt_i[0] = pc;
        @(negedge clk);
        n_tests++;
        if (bank_pkt_ready_and_o !== 2'b10) begin n_fail++; $display("FAIL out_second got=%b exp=10", bank_pkt_ready_and_o); end
        cyc();
        bank_pkt_v_i = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (bank_pkt_ready_and_o !== 2'b00 || dma_pkt_v_o !== 1'b0) begin
                n_fail++;
                $display("FAIL out_full_stall cyc=%0d ready=%b v=%b exp ready=00 v=0", i, bank_pkt_ready_and_o, dma_pkt_v_o);
            end
            cyc();
        end
        for (int i = 0; i < 2; i++) begin
            dma_data_i = 64'hC0 + 64'(i);
            dma_data_v_i = 1'b1;
            exp_ret.push_back({1'b0, dma_data_i});
            @(negedge clk);
            n_tests++;
            if (bank_pkt_ready_and_o !== 2'b00) begin n_fail++; $display("FAIL out_pop_stall beat=%0d got=%b exp=00", i, bank_pkt_ready_and_o); end
            cyc();
        end
        dma_data_v_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bank_pkt_ready_and_o !== 2'b01 || dma_pkt_v_o !== 1'b1) begin
            n_fail++;
            $display("FAIL out_third_issue ready=%b v=%b exp ready=01 v=1", bank_pkt_ready_and_o, dma_pkt_v_o);
        end
        cyc();
        bank_pkt_v_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            dma_data_i = 64'hD0 + 64'(i);
            dma_data_v_i = 1'b1;
            exp_ret.push_back({(i < 2) ? 1'b1 : 1'b0, dma_data_i});
            cyc();
        end
        dma_data_v_i = 1'b0;
    endtask

    task automatic test_write_priority();
        bank_pkt_i[1] = mkpkt(1'b1, 32'h0000_5000, 8'hFF);
        bank_pkt_i[0] = mkpkt(1'b0, 32'h0000_6000, 8'hF0);
        bank_pkt_v_i = 2'b11;
        exp_pkt.push_back(bank_pkt_i[1]);
        exp_pkt.push_back(bank_pkt_i[0]);
        @(negedge clk);
        n_tests++;
        if (bank_pkt_ready_and_o !== 2'b10) begin n_fail++; $display("FAIL wr_grant got=%b exp=10", bank_pkt_ready_and_o); end
        cyc();
        bank_pkt_v_i = 2'b01;
        for (int i = 0; i < 2; i++) begin
            bank_data_i[1] = 64'hB0 + 64'(i);
            bank_data_i[0] = 64'hDEAD_BEEF;
            bank_data_v_i = 2'b11;
            exp_wdata.push_back(bank_data_i[1]);
            @(negedge clk);
            n_tests++;
            if (dma_pkt_v_o !== 1'b0 || bank_pkt_ready_and_o !== 2'b00) begin
                n_fail++;
                $display("FAIL wr_pkt_blocked beat=%0d v=%b ready=%b exp v=0 ready=00", i, dma_pkt_v_o, bank_pkt_ready_and_o);
            end
            n_tests++;
            if (bank_data_ready_and_o !== 2'b10) begin n_fail++; $display("FAIL wr_data_ready beat=%0d got=%b exp=10", i, bank_data_ready_and_o); end
            cyc();
        end
        bank_data_v_i = 2'b00;
        @(negedge clk);
        n_tests++;
        if (bank_pkt_ready_and_o !== 2'b01 || dma_data_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_read_after ready=%b wv=%b exp ready=01 wv=0", bank_pkt_ready_and_o, dma_data_v_o);
        end
        cyc();
        bank_pkt_v_i = 2'b00;
    endtask

    task automatic test_concurrent();
        bank_pkt_i[1] = mkpkt(1'b1, 32'h0000_7000, 8'h3C);
        bank_pkt_v_i = 2'b10;
        exp_pkt.push_back(bank_pkt_i[1]);
        dma_data_i = 64'hE100;
        dma_data_v_i = 1'b1;
        exp_ret.push_back({1'b0, dma_data_i});
        @(negedge clk);
        n_tests++;
        if (bank_data_v_o !== 2'b01) begin n_fail++; $display("FAIL conc_ret0 got=%b exp=01", bank_data_v_o); end
        cyc();
        bank_pkt_v_i = 2'b00;
        bank_data_i[1] = 64'hE000;
        bank_data_v_i = 2'b10;
        exp_wdata.push_back(bank_data_i[1]);
        dma_data_i = 64'hE101;
        exp_ret.push_back({1'b0, dma_data_i});
        @(negedge clk);
        n_tests++;
        if (dma_data_v_o !== 1'b1 || bank_data_v_o !== 2'b01) begin
            n_fail++;
            $display("FAIL conc_both wv=%b rv=%b exp wv=1 rv=01", dma_data_v_o, bank_data_v_o);
        end
        cyc();
        bank_data_i[1] = 64'hE001;
        exp_wdata.push_back(bank_data_i[1]);
        dma_data_v_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (dma_data_v_o !== 1'b1 || dma_data_ready_and_o !== 1'b0) begin
            n_fail++;
            $display("FAIL conc_tail wv=%b rready=%b exp wv=1 rready=0", dma_data_v_o, dma_data_ready_and_o);
        end
        cyc();
        bank_data_v_i = 2'b00;
    endtask

    task automatic test_ready_stall();
        bank_pkt_i[0] = mkpkt(1'b0, 32'h0000_8000, 8'hAA);
        bank_pkt_v_i = 2'b01;
        exp_pkt.push_back(bank_pkt_i[0]);
        @(negedge clk);
        n_tests++;
        if (bank_pkt_ready_and_o !== 2'b01) begin n_fail++; $display("FAIL stall_grant got=%b exp=01", bank_pkt_ready_and_o); end
        cyc();
        bank_pkt_v_i = 2'b00;
        dma_data_i = 64'hF0;
        dma_data_v_i = 1'b1;
        bank_data_ready_and_i = 2'b10;
        exp_ret.push_back({1'b0, dma_data_i});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (dma_data_ready_and_o !== 1'b0 || bank_data_v_o !== 2'b01) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d rready=%b bv=%b exp rready=0 bv=01", i, dma_data_ready_and_o, bank_data_v_o);
            end
            cyc();
        end
        bank_data_ready_and_i = 2'b11;
        @(negedge clk);
        n_tests++;
        if (dma_data_ready_and_o !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b exp=1", dma_data_ready_and_o); end
        cyc();
        dma_data_i = 64'hF1;
        exp_ret.push_back({1'b0, dma_data_i});
        cyc();
        dma_data_v_i = 1'b0;
    endtask

    task automatic test_reset_midburst();
        bank_pkt_i[1] = mkpkt(1'b0, 32'h0000_9000, 8'h55);
        bank_pkt_v_i = 2'b10;
        exp_pkt.push_back(bank_pkt_i[1]);
        cyc();
        bank_pkt_i[0] = mkpkt(1'b1, 32'h0000_A000, 8'hFF);
        bank_pkt_v_i = 2'b01;
        exp_pkt.push_back(bank_pkt_i[0]);
        cyc();
        bank_pkt_v_i = 2'b00;
        bank_data_i[0] = 64'h1234;
        bank_data_v_i = 2'b01;
        exp_wdata.push_back(bank_data_i[0]);
        cyc();
        bank_data_i[0] = 64'h5678;
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        dma_data_v_i = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dma_data_v_o !== 1'b0 || bank_data_ready_and_o !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid_write wv=%b wready=%b exp wv=0 wready=00", dma_data_v_o, bank_data_ready_and_o);
        end
        n_tests++;
        if (dma_data_ready_and_o !== 1'b0 || bank_data_v_o !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid_fifo rready=%b bv=%b exp rready=0 bv=00", dma_data_ready_and_o, bank_data_v_o);
        end
        n_tests++;
        if (dma_pkt_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pkt_v got=%b exp=0", dma_pkt_v_o); end
        cyc();
        bank_data_v_i = 2'b00;
        dma_data_v_i = 1'b0;
        cyc();
    endtask

    initial begin
        #1;
        test_reset();
        test_rr_reads();
        test_outstanding();
        test_write_priority();
        test_concurrent();
        test_ready_stall();
        test_reset_midburst();
        n_tests++;
        if (exp_pkt.size() != 0 || exp_wdata.size() != 0 || exp_ret.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover pkt=%0d wdata=%0d ret=%0d exp all 0",
                     exp_pkt.size(), exp_wdata.size(), exp_ret.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_me_dma_bank_mux.md
BP_ME_DMA_BANK_MUX -- requirements
Module: bp_me_dma_bank_mux

Interface
REQ-001 SHALL have parameter banks_p, default 2: number of L2 bank DMA channels merged.
REQ-002 SHALL have parameter daddr_width_p, default 32: DMA address width.
REQ-003 SHALL have parameter block_size_in_words_p, default 8: mask width per packet.
REQ-004 SHALL have parameter fill_width_p, default 64: DMA data beat width.
REQ-005 SHALL have parameter block_beats_p, default 8: data beats per block, >=1.
REQ-006 SHALL have parameter max_outstanding_p, default 4: read tag FIFO depth, >=1.
REQ-007 SHALL derive pkt width = 1 + daddr_width_p + block_size_in_words_p, with fields {write_not_read, addr, mask} MSB-first.
REQ-008 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-009 reset_i  in  1  synchronous, active-low reset (0 = reset).
REQ-010 bank_pkt_i  in  banks_p x pkt width  per-bank DMA packet.
REQ-011 bank_pkt_v_i / bank_pkt_ready_and_o  in/out  banks_p  per-bank packet handshake.
REQ-012 bank_data_i / bank_data_v_i / bank_data_ready_and_o  in/in/out  banks_p x fill_width_p / banks_p / banks_p  per-bank write data.
REQ-013 bank_data_o / bank_data_v_o / bank_data_ready_and_i  out/out/in  banks_p x fill_width_p / banks_p / banks_p  per-bank read return data.
REQ-014 dma_pkt_o / dma_pkt_v_o / dma_pkt_ready_and_i  out/out/in  pkt width / 1 / 1  merged DRAM packet.
REQ-015 dma_data_o / dma_data_v_o / dma_data_ready_and_i  out/out/in  fill_width_p / 1 / 1  merged write data.
REQ-016 dma_data_i / dma_data_v_i / dma_data_ready_and_o  in/in/out  fill_width_p / 1 / 1  merged read data.

Function
REQ-017 All handshakes SHALL be ready-and-valid; transfer occurs when v & ready in the same cycle; valid never depends combinationally on ready of the same channel.
REQ-018 Packet FSM SHALL have states IDLE and WRITE.
REQ-019 IDLE: round-robin arbiter over eligible banks (pkt_v_i=1, and if read, tag FIFO not full) SHALL select one grant; pointer starts at bank 0 after reset.
REQ-020 dma_pkt_o SHALL equal granted bank's packet unmodified; dma_pkt_v_o = any eligible; bank_pkt_ready_and_o[g] = dma_pkt_ready_and_i for granted g only, 0 for others.
REQ-021 On packet transfer, arbiter pointer SHALL advance to g+1 mod banks_p; without transfer pointer and grant stay fixed (no grant switching while dma_pkt_v_o held).
REQ-022 On read packet transfer, bank id g SHALL be pushed into tag FIFO; FSM remains IDLE.
REQ-023 On write packet transfer, FSM SHALL latch g, go to WRITE, clear write beat counter.
REQ-024 WRITE: dma_data_o/v_o = bank_data_i/v_i[g]; bank_data_ready_and_o[g] = dma_data_ready_and_i; others 0; dma_pkt_v_o = 0.
REQ-025 WRITE: each data transfer increments counter; transfer on count block_beats_p-1 returns FSM to IDLE next cycle.
REQ-026 Read return: while tag FIFO non-empty, dma_data_i routes to bank h = FIFO head; bank_data_v_o[h] = dma_data_v_i; dma_data_ready_and_o = bank_data_ready_and_i[h]; all other bank_data_v_o = 0.
REQ-027 FIFO empty: dma_data_ready_and_o = 0, all bank_data_v_o = 0.
REQ-028 Read beat counter SHALL increment per return transfer; on beat block_beats_p-1 FIFO pops and counter clears.
REQ-029 Simultaneous push and pop in one cycle SHALL be legal, including when full (read grant allowed when pop occurs that cycle is NOT required; full blocks reads).
REQ-030 Write data and read return channels SHALL operate concurrently and independently.
REQ-031 Read returns SHALL be delivered in issue order; data ordering per bank preserved.
REQ-032 Counters SHALL be clog2(block_beats_p) wide, min 1 bit; block_beats_p=1 makes every beat final.

Reset
REQ-033 While reset_i=0 on a clock edge: FSM->IDLE, pointer->0, tag FIFO empty, both counters->0.
REQ-034 Outputs after reset: dma_pkt_v_o=0 unless inputs valid, dma_data_v_o=0, dma_data_ready_and_o=0, all bank_data_v_o=0, all bank ready outputs=0 unless granted.
REQ-035 Reset mid-burst SHALL discard in-flight write/read state; no beats forwarded to any bank after reset without new packet.

Verification
REQ-036 banks_p=2, beats=2: banks 0,1 both issue reads simultaneously, DRAM always ready -> dma_pkt_o bank0 then bank1; returns 4 beats: first 2 to bank0, next 2 to bank1.
REQ-037 max_outstanding_p=2: three reads back-to-back, no returns -> third pkt stalled (bank_pkt_ready_and_o=0) until 2 beats returned, then issued.
REQ-038 Bank1 write, beats=2, bank0 read pending -> write pkt, 2 write beats from bank1 only; bank0 read pkt not issued until cycle after final beat.
REQ-039 Write burst in progress while read return arrives -> both channels transfer same cycle; no corruption.
REQ-040 Bank data ready low on return beat -> dma_data_ready_and_o=0, beat held, delivered when ready rises.
REQ-041 reset_i=0 during beat 1 of a write -> next cycle FSM IDLE, dma_data_v_o=0, FIFO empty.
